// File: rtl/sp_mem_initiator.sv
// Valid/ready front end for a single-port bit-masked memory, with a 2-entry response queue.
// Define INIT_CLEAR_EN to zero every memory word after reset before requests are served.
module sp_mem_initiator #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [MEM_ADDRWIDTH-1:0] req_addr,
    input  logic [MEM_DATAWIDTH-1:0] req_wdata,
    input  logic [MEM_DATAWIDTH-1:0] req_wmask,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MEM_DATAWIDTH-1:0] rsp_rdata,
    output logic                     init_done,
    output logic                     mem_en,
    output logic [MEM_DATAWIDTH-1:0] mem_we,
    output logic [MEM_ADDRWIDTH-1:0] mem_addr,
    output logic [MEM_DATAWIDTH-1:0] mem_din,
    input  logic [MEM_DATAWIDTH-1:0] mem_dout
);
    localparam int DW = MEM_DATAWIDTH;
    localparam int AW = MEM_ADDRWIDTH;

    typedef enum logic {ST_INIT, ST_SERVE} state_e;

    state_e        state_q, state_d;
    logic          live_q;
    logic          inflight_q;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          serving, accept, push, pop;
    logic [1:0]    pending;
`ifdef INIT_CLEAR_EN
    logic [AW:0]   cnt_q, cnt_d;
`endif

    // live_q keeps every output quiet while reset is held and until the first clock after release.
    assign serving   = live_q && (state_q == ST_SERVE);
    assign push      = inflight_q;
    assign pop       = (occ_q != 2'd0) && rsp_ready;
    assign pending   = occ_q + {1'b0, inflight_q};
    // A same-cycle pop frees a slot, which is what lets back-to-back reads run at one per cycle.
    assign req_ready = serving && (pending < (2'd2 + {1'b0, pop}));
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (occ_q != 2'd0);
    assign rsp_rdata = head_q;
    assign init_done = serving;
    assign mem_addr  = addr_d;
    assign mem_din   = din_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        mem_we  = '0;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef INIT_CLEAR_EN
        cnt_d   = cnt_q;
        if (live_q && state_q == ST_INIT) begin
            mem_en = 1'b1;
            mem_we = '1;
            addr_d = cnt_q[AW-1:0];
            din_d  = '0;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_d[AW]) state_d = ST_SERVE;
        end
`endif
        if (accept) begin
            mem_en = 1'b1;
            mem_we = req_write ? req_wmask : '0;
            addr_d = req_addr;
            din_d  = req_wdata;
        end
    end

    // Reservation guarantees a push never meets a full queue.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = mem_dout;
                else               tail_d = mem_dout;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = mem_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = mem_dout;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the queue data registers are reset too, so rsp_rdata reads 0 while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef INIT_CLEAR_EN
            state_q <= ST_INIT;
            cnt_q   <= '0;
`else
            state_q <= ST_SERVE;
`endif
            live_q     <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
`ifdef INIT_CLEAR_EN
            cnt_q <= cnt_d;
`endif
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state_q    <= state_d;
            live_q     <= 1'b1;
            inflight_q <= accept && !req_write;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

endmodule
